// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, reset/NOP constants, PC alignment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] FETCH_NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction addresses are word aligned; the low two bits of any target are discarded.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Fetch-stage front end: owns the fetch PC, issues one imem request at a time,
// holds the returned word until decode takes it, and discards responses made stale by redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = FETCH_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid_f,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic        fetch_fire
);

  fetch_state_e state;
  logic [31:0]  redirect_target;

  assign redirect_target = align_pc(redirect_pc);
  assign pc_plus4_f      = pc_f + 32'd4;
  assign imem_req_valid  = (state == S_REQ) & ~redirect_valid & ~reset;
  assign imem_req_addr   = pc_f;
  assign fetch_fire      = instr_valid_f & ~stall_f & ~redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_REQ;
      pc_f          <= RESET_PC;
      instr_valid_f <= 1'b0;
      instr_f       <= NOP_INSTR;
    end else begin
      unique case (state)
        S_REQ: begin
          if (redirect_valid) begin
            pc_f <= redirect_target;
          end else if (imem_req_ready) begin
            state <= S_WAIT;
          end
        end

        // A redirect while the request is in flight must not let its response through.
        S_WAIT: begin
          if (redirect_valid) begin
            pc_f  <= redirect_target;
            state <= imem_resp_valid ? S_REQ : S_DROP;
          end else if (imem_resp_valid) begin
            instr_f       <= imem_resp_data;
            instr_valid_f <= 1'b1;
            state         <= S_HOLD;
          end
        end

        S_DROP: begin
          if (redirect_valid) begin
            pc_f <= redirect_target;
          end
          if (imem_resp_valid) begin
            state <= S_REQ;
          end
        end

        S_HOLD: begin
          if (redirect_valid) begin
            instr_valid_f <= 1'b0;
            instr_f       <= NOP_INSTR;
            pc_f          <= redirect_target;
            state         <= S_REQ;
          end else if (!stall_f) begin
            instr_valid_f <= 1'b0;
            instr_f       <= NOP_INSTR;
            pc_f          <= pc_plus4_f;
            state         <= S_REQ;
          end
        end

        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Fetch-stage front end that sits directly upstream of the IF/ID register.
- Owns the fetch PC and issues one instruction-memory request at a time over a valid/ready request channel and a valid-only response channel.
- Holds the returned instruction until the decode side accepts it.
- Applies branch/jump redirects, and discards any in-flight response made stale by a redirect.
- Its hand-off strobe drives the IF/ID register's enable; its pc_plus4_f drives that register's pc_next_f input.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset (word aligned)
NOP_INSTR, 32'h0000_0013, value of instr_f when no valid instruction is held

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall_f  input  1  hazard unit: downstream cannot accept an instruction this cycle
redirect_valid  input  1  control-flow change resolved downstream; overrides stall_f
redirect_pc  input  32  new fetch target; bits [1:0] are ignored and forced to 2'b00
imem_req_valid  output  1  request presented to instruction memory
imem_req_addr  output  32  request address, always equal to pc_f
imem_req_ready  input  1  memory accepts the request this cycle
imem_resp_valid  input  1  instruction data returned this cycle (in order, one per accepted request)
imem_resp_data  input  32  returned instruction word
instr_valid_f  output  1  instr_f/pc_f hold a valid instruction
instr_f  output  32  fetched instruction
pc_f  output  32  address of the current fetch / held instruction
pc_plus4_f  output  32  pc_f + 4, modulo 2^32
fetch_fire  output  1  instr_valid_f & ~stall_f & ~redirect_valid; enable for the IF/ID register

Behaviour:
- Reset (synchronous, active-high):
  - state = S_REQ, pc_f = RESET_PC, instr_valid_f = 0, instr_f = NOP_INSTR.
  - imem_req_valid = 0 while reset is high.
  - Instruction memory shares this reset and drops outstanding requests. No response arrives for a pre-reset request.
- Reset mid-operation: reset overrides every state, including S_WAIT and S_DROP, within one cycle.
- imem_req_valid = (state == S_REQ) & ~redirect_valid & ~reset. The request handshake completes when imem_req_valid & imem_req_ready.
- pc_plus4_f is combinational; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- S_REQ:
  - If redirect_valid: pc_f <= {redirect_pc[31:2], 2'b00}; stay in S_REQ.
  - Else if handshake: go to S_WAIT.
  - Else: stay in S_REQ, holding imem_req_addr stable.
- S_WAIT:
  - If redirect_valid: pc_f <= redirect; go to S_REQ if imem_resp_valid is high this cycle (response discarded), else go to S_DROP.
  - Else if imem_resp_valid: instr_f <= imem_resp_data, instr_valid_f <= 1; go to S_HOLD.
- S_DROP:
  - Waits for the stale response.
  - On imem_resp_valid: discard it, go to S_REQ.
  - A further redirect_valid updates pc_f and stays in S_DROP, unless imem_resp_valid is high the same cycle, in which case go to S_REQ.
- S_HOLD:
  - If redirect_valid: instr_valid_f <= 0, instr_f <= NOP_INSTR, pc_f <= redirect; go to S_REQ.
  - Else if ~stall_f (fetch_fire = 1): instr_valid_f <= 0, instr_f <= NOP_INSTR, pc_f <= pc_plus4_f; go to S_REQ.
  - Else: hold all outputs unchanged.
- Priority: reset > redirect_valid > stall_f.
- Outside S_WAIT/S_DROP, imem_resp_valid is a protocol error and is ignored.
- Latency: request accepted at edge T, response in cycle T+k, instr_valid_f high from cycle T+k+1.
- Peak throughput: one instruction per 3 cycles when k = 1.

Decomposition:
- Shared package fetch_pkg holds:
  - 2-bit state localparams S_REQ = 0, S_WAIT = 1, S_HOLD = 2, S_DROP = 3.
  - NOP_INSTR constant.
  - Default RESET_PC.
- No sub-module: FSM, PC register and instruction holding register live in one module.

Test Plan:
1. Reset, then ready = 1 and a 1-cycle response of 32'h00500093 -> req addr 0; instr_valid_f high at cycle 3 with pc_f = 0, pc_plus4_f = 4; fetch_fire pulses; next request addr 4.
2. stall_f held 4 cycles while in S_HOLD -> instr_f and pc_f unchanged and fetch_fire = 0; on release one fire occurs, next request addr pc + 4, no duplicate instruction.
3. redirect_valid to 32'h0000_0103 during S_WAIT, response 2 cycles later -> stale data never appears on instr_f; next request addr 32'h0000_0100.
4. redirect_valid and stall_f together in S_HOLD -> held instruction dropped, instr_valid_f = 0 next cycle, request to the redirect target.
5. RESET_PC = 32'hFFFF_FFFC -> pc_plus4_f = 0; after hand-off the next request addr is 32'h0000_0000.
6. reset asserted during S_DROP -> next cycle pc_f = RESET_PC, instr_valid_f = 0, imem_req_valid = 1 after reset falls.
